flash_word_fetch: RTL and testbench
===================================

// Module: flash_word_fetch
// PURPOSE
//   SPI flash read controller that fetches one 32-bit word per request using the
//   standard READ (0x03) command, SPI mode 0. Sits directly upstream of
//   instruction_memory: instruction_memory issues a byte address and consumes the
//   assembled word. It owns flashClk/flashCs/flashMosi and samples flashMiso.
// PARAMETERS
//   CLK_DIV         1     SCK half-period in clock cycles (>=1); SCK = clock/(2*CLK_DIV)
//   POWERUP_CYCLES  5400  clock cycles to wait after reset before first request (>=1)
//   LITTLE_ENDIAN   1     1: first byte read -> rsp_data[7:0]; 0: first byte -> [31:24]
// PORTS
//   clock      in   1   system clock, all logic on posedge
//   reset      in   1   synchronous, active-high
//   req_valid  in   1   read request present
//   req_addr   in   24  flash byte address (no alignment required)
//   req_ready  out  1   controller idle, accepts request this cycle
//   rsp_valid  out  1   one-cycle pulse, rsp_data valid
//   rsp_data   out  32  fetched word; held until next rsp_valid
//   flashClk   out  1   SPI SCK, idle low
//   flashCs    out  1   SPI chip select, active low
//   flashMosi  out  1   SPI data to flash
//   flashMiso  in   1   SPI data from flash
// BEHAVIOUR
//   Reset: req_ready=0, rsp_valid=0, rsp_data=0, flashCs=1, flashClk=0, flashMosi=0;
//     FSM->POWERUP, all counters cleared. Reset mid-transaction aborts at once (CS high
//     next edge, no rsp_valid) and restarts the POWERUP wait.
//   States: POWERUP -> IDLE -> SHIFT -> DONE -> IDLE.
//   POWERUP: count POWERUP_CYCLES cycles, then IDLE.
//   IDLE: req_ready=1 (combinational from state, only here). Accept on
//     req_valid&&req_ready at edge T: latch {8'h03, req_addr} into 32-bit shift reg,
//     flashCs=0 and flashMosi=bit31 (0) from T+1, bit counter=0, -> SHIFT.
//   SHIFT: 64 bits, MSB first: 8 cmd + 24 addr out on MOSI, then 32 data in.
//     Each bit = 2*CLK_DIV cycles: SCK low CLK_DIV cycles, high CLK_DIV cycles.
//     MOSI changes only on the edge that drives SCK low (or CS fall for bit 0).
//     MISO sampled on the edge that drives SCK high, data bits 32..63 only.
//     MOSI held 0 during data bits. After bit 63 high phase: SCK=0, CS=1, -> DONE.
//   DONE: one cycle; rsp_valid=1, rsp_data = assembled word (byte-reordered per
//     LITTLE_ENDIAN); req_ready=0 here, guaranteeing >=1 clock CS-high gap.
//   Latency: accept edge T -> rsp_valid high in cycle T+1+128*CLK_DIV (exactly).
//   req_valid while not IDLE: ignored, not queued; req_addr sampled only at accept.
//   Addr wrap: 24-bit address sent as-is; flash wraps 0xFFFFFF->0x000000 internally.
//   Back-to-back: next request accepted earliest cycle after DONE.
// TESTING
//   1 Reset, POWERUP_CYCLES=8: req_ready stays 0 for 8 cycles, then 1; CS=1, SCK=0 throughout.
//   2 Flash model bytes 13 05 10 00 @0x000000, req 0x000000, CLK_DIV=1 -> MOSI stream
//     0x03000000, rsp_valid exactly 129 cycles after accept, rsp_data=0x00100513.
//   3 Same, LITTLE_ENDIAN=0 -> rsp_data=0x13051000; CLK_DIV=3 -> latency 385 cycles.
//   4 req 0xFFFFFE, model bytes AA BB @FFFFFE, 11 22 @000000 -> rsp_data=0x2211BBAA.
//   5 req_valid held high continuously: exactly one accept per 130 cycles (CLK_DIV=1),
//     CS high >=1 cycle between transactions; addr change mid-SHIFT has no effect.
//   6 Assert reset at bit 40 of SHIFT: CS=1, SCK=0 next cycle, no rsp_valid, rsp_data=0,
//     req_ready returns only after POWERUP_CYCLES.

Source files
------------

// File: rtl/flash_word_fetch.sv
// -----------------------------------------------------------------------------
// flash_word_fetch
//   SPI (mode 0) flash read controller. Each accepted request issues a standard
//   READ (0x03) command with a 24-bit byte address, then clocks in one 32-bit
//   word and returns it on a single-cycle response pulse. It sits upstream of
//   instruction_memory, which supplies byte addresses and consumes words.
//
// Parameters
//   CLK_DIV         SCK half-period in clock cycles (>=1)
//   POWERUP_CYCLES  cycles to wait after reset before the first request (>=1)
//   LITTLE_ENDIAN   1: first byte read -> rsp_data[7:0]; 0: -> rsp_data[31:24]
//
// Ports
//   clock      in   system clock, everything on posedge
//   reset      in   synchronous, active-high
//   req_valid  in   read request present
//   req_addr   in   [23:0] flash byte address, sampled only on accept
//   req_ready  out  controller idle; decoded from state, high only in IDLE
//   rsp_valid  out  one-cycle pulse, rsp_data valid
//   rsp_data   out  [31:0] fetched word, held until the next rsp_valid
//   flashClk   out  SPI SCK, idle low
//   flashCs    out  SPI chip select, active low
//   flashMosi  out  SPI data to flash
//   flashMiso  in   SPI data from flash
// -----------------------------------------------------------------------------
module flash_word_fetch #(
    parameter int unsigned CLK_DIV        = 1,
    parameter int unsigned POWERUP_CYCLES = 5400,
    parameter int unsigned LITTLE_ENDIAN  = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [23:0] req_addr,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        flashClk,
    output logic        flashCs,
    output logic        flashMosi,
    input  logic        flashMiso
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned PWR_W = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(POWERUP_CYCLES - 1);
    localparam logic [7:0]       CMD_READ = 8'h03;
    localparam logic [5:0]       LAST_BIT = 6'd63;
    localparam logic [5:0]       LAST_TX  = 6'd31;

    typedef enum logic [1:0] {
        S_POWERUP = 2'd0,
        S_IDLE    = 2'd1,
        S_SHIFT   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t             r_state;
    logic [PWR_W-1:0]   r_pwr_cnt;
    logic [DIV_W-1:0]   r_div_cnt;
    logic [5:0]         r_bit_cnt;
    // Holds {cmd, addr} while transmitting, then collects the 32 data bits
    logic [31:0]        r_shift;

    logic               w_div_end;
    logic [31:0]        w_word;

    assign req_ready = (r_state == S_IDLE);
    assign w_div_end = (r_div_cnt == DIV_LAST);

    // Flash returns bytes in address order; the first byte lands in r_shift[31:24]
    assign w_word = (LITTLE_ENDIAN != 0)
                  ? {r_shift[7:0], r_shift[15:8], r_shift[23:16], r_shift[31:24]}
                  : r_shift;

    // Controller: power-up wait, request accept, 64-bit SPI transfer, response
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_POWERUP;
            r_pwr_cnt <= '0;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            flashClk  <= 1'b0;
            flashCs   <= 1'b1;
            flashMosi <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_POWERUP: begin
                    if (r_pwr_cnt == PWR_LAST) begin
                        r_pwr_cnt <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_pwr_cnt <= r_pwr_cnt + PWR_W'(1);
                    end
                end

                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_shift   <= {CMD_READ, req_addr};
                        flashCs   <= 1'b0;
                        flashClk  <= 1'b0;
                        // Bit 0 is presented with the CS fall
                        flashMosi <= CMD_READ[7];
                        r_bit_cnt <= '0;
                        r_div_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    if (!w_div_end) begin
                        r_div_cnt <= r_div_cnt + DIV_W'(1);
                    end else begin
                        r_div_cnt <= '0;
                        if (!flashClk) begin
                            // Rising SCK: flash data is stable, capture it in the data half
                            flashClk <= 1'b1;
                            if (r_bit_cnt[5]) begin
                                r_shift <= {r_shift[30:0], flashMiso};
                            end
                        end else begin
                            // Falling SCK: end of bit; advance MOSI or finish
                            flashClk <= 1'b0;
                            if (r_bit_cnt == LAST_BIT) begin
                                flashCs   <= 1'b1;
                                flashMosi <= 1'b0;
                                rsp_valid <= 1'b1;
                                rsp_data  <= w_word;
                                r_state   <= S_DONE;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 6'd1;
                                if (r_bit_cnt < LAST_TX) begin
                                    r_shift   <= {r_shift[30:0], 1'b0};
                                    flashMosi <= r_shift[30];
                                end else begin
                                    // Data half: MOSI parked low, register left for capture
                                    flashMosi <= 1'b0;
                                end
                            end
                        end
                    end
                end

                // One cycle with CS high before the next request can be taken
                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_POWERUP;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_word_fetch.sv
// -----------------------------------------------------------------------------
// tb_flash_word_fetch
//   Two controller instances (CLK_DIV=1/little-endian and CLK_DIV=3/big-endian)
//   each attached to a behavioural SPI READ flash model that shares one sparse
//   byte memory. Expected words come from that memory and the byte-order rule.
// -----------------------------------------------------------------------------
module tb_flash_word_fetch;

    localparam int unsigned PWR = 8;

    logic        clock = 1'b0;
    logic        reset;

    logic        rv0, rv1;
    logic [23:0] ra0, ra1;
    logic        rdy0, rdy1, vld0, vld1;
    logic [31:0] dat0, dat1;
    logic        sck0, sck1, cs0, cs1, mosi0, mosi1;
    logic [1:0]  mval = 2'b00;

    int n_cmp = 0;
    int n_bad = 0;

    flash_word_fetch #(.CLK_DIV(1), .POWERUP_CYCLES(PWR), .LITTLE_ENDIAN(1)) u_dut0 (
        .clock(clock), .reset(reset), .req_valid(rv0), .req_addr(ra0),
        .req_ready(rdy0), .rsp_valid(vld0), .rsp_data(dat0), .flashClk(sck0),
        .flashCs(cs0), .flashMosi(mosi0), .flashMiso(mval[0]));

    flash_word_fetch #(.CLK_DIV(3), .POWERUP_CYCLES(PWR), .LITTLE_ENDIAN(0)) u_dut1 (
        .clock(clock), .reset(reset), .req_valid(rv1), .req_addr(ra1),
        .req_ready(rdy1), .rsp_valid(vld1), .rsp_data(dat1), .flashClk(sck1),
        .flashCs(cs1), .flashMosi(mosi1), .flashMiso(mval[1]));

    initial forever #5 clock = ~clock;

    // ---------------- flash memory and SPI READ model ----------------
    logic [7:0]  fmem [int];
    logic [1:0]  pclk = 2'b00;
    int          fcnt [2];
    logic [31:0] fcap [2];
    int          mosi_bad [2];

    function automatic logic [7:0] flash_byte(logic [23:0] a);
        if (fmem.exists(int'(a))) return fmem[int'(a)];
        return 8'((a * 24'd7) ^ (a >> 11) ^ 24'h00005A);
    endfunction

    function automatic logic [31:0] exp_word(logic [23:0] a, bit le);
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) b[i] = flash_byte(24'(a + 24'(i)));
        return le ? {b[3], b[2], b[1], b[0]} : {b[0], b[1], b[2], b[3]};
    endfunction

    always @(sck0 or cs0 or sck1 or cs1) begin : flash_model
        logic s, c, mo;
        int   k;
        logic [7:0] bt;
        for (int ch = 0; ch < 2; ch++) begin
            s  = (ch == 0) ? sck0  : sck1;
            c  = (ch == 0) ? cs0   : cs1;
            mo = (ch == 0) ? mosi0 : mosi1;
            if (c !== 1'b0) begin
                fcnt[ch] = 0;
                mval[ch] = 1'b0;
            end else if (s === 1'b1 && pclk[ch] === 1'b0) begin
                if (fcnt[ch] < 32) fcap[ch] = {fcap[ch][30:0], mo};
                else if (mo !== 1'b0) mosi_bad[ch]++;
                fcnt[ch]++;
            end else if (s === 1'b0 && pclk[ch] === 1'b1 && fcnt[ch] >= 32 && fcnt[ch] < 64) begin
                k  = fcnt[ch] - 32;
                bt = flash_byte(24'(fcap[ch][23:0] + 24'(k / 8)));
                mval[ch] = bt[7 - (k % 8)];
            end
            pclk[ch] = s;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_rdy(int ch); return (ch == 0) ? rdy0 : rdy1; endfunction
    function automatic logic get_vld(int ch); return (ch == 0) ? vld0 : vld1; endfunction
    function automatic logic get_cs (int ch); return (ch == 0) ? cs0  : cs1;  endfunction
    function automatic logic get_sck(int ch); return (ch == 0) ? sck0 : sck1; endfunction
    function automatic logic [31:0] get_dat(int ch); return (ch == 0) ? dat0 : dat1; endfunction

    task automatic set_req(int ch, logic v, logic [23:0] a);
        if (ch == 0) begin rv0 = v; ra0 = a; end
        else         begin rv1 = v; ra1 = a; end
    endtask

    task automatic wait_ready(int ch, string tag);
        int k = 0;
        while (get_rdy(ch) !== 1'b1 && k < 2000) begin @(negedge clock); k++; end
        check({tag, "_ready"}, 64'(get_rdy(ch)), 64'd1);
    endtask

    // Counts cycles with req_ready low after reset release; called at the negedge reset drops
    task automatic wait_powerup(string tag);
        int n = 0;
        while (rdy0 !== 1'b1 && n < 100) begin
            if (cs0 !== 1'b1 || sck0 !== 1'b0 || vld0 !== 1'b0)
                check({tag, "_pins_pwr"}, 64'({cs0, sck0, vld0}), 64'b100);
            @(negedge clock);
            n++;
        end
        check({tag, "_pwr_cycles"}, 64'(n), 64'(PWR));
        check({tag, "_pwr_ready1"}, 64'(rdy1), 64'd1);
    endtask

    // One request from IDLE; checks latency, MOSI stream, data and response shape
    task automatic run_txn(int ch, logic [23:0] a, string tag);
        int k;
        int lat = 1 + 128 * ((ch == 0) ? 1 : 3);
        logic [31:0] d;
        wait_ready(ch, tag);
        set_req(ch, 1'b1, a);
        @(negedge clock);
        set_req(ch, 1'b0, 24'($urandom));
        k = 1;
        check({tag, "_cs_low"}, 64'(get_cs(ch)), 64'd0);
        while (get_vld(ch) !== 1'b1 && k < lat + 50) begin @(negedge clock); k++; end
        check({tag, "_latency"}, 64'(k), 64'(lat));
        check({tag, "_mosi"}, 64'(fcap[ch]), 64'({8'h03, a}));
        d = exp_word(a, ch == 0);
        check({tag, "_data"}, 64'(get_dat(ch)), 64'(d));
        check({tag, "_mosi_idle"}, 64'(mosi_bad[ch]), 64'd0);
        @(negedge clock);
        check({tag, "_pulse"}, 64'({get_vld(ch), get_cs(ch), get_sck(ch)}), 64'b010);
        check({tag, "_held"}, 64'(get_dat(ch)), 64'(d));
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        logic [23:0] a;
        logic [23:0] aq [$];
        int cyc, nacc, nrsp, last_acc, gap, k;

        mosi_bad[0] = 0; mosi_bad[1] = 0;
        fcnt[0] = 0; fcnt[1] = 0;
        reset = 1'b1;
        set_req(0, 1'b0, 24'h0);
        set_req(1, 1'b0, 24'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);

        // Reset values
        check("rst_ready", 64'({rdy0, rdy1}), 64'd0);
        check("rst_valid", 64'({vld0, vld1}), 64'd0);
        check("rst_data", 64'({dat0, dat1}), 64'd0);
        check("rst_pins", 64'({cs0, sck0, mosi0, cs1, sck1, mosi1}), 64'b100100);
        reset = 1'b0;
        wait_powerup("pwr");

        // Known word at address 0 on both byte orders / dividers
        fmem[0] = 8'h13; fmem[1] = 8'h05; fmem[2] = 8'h10; fmem[3] = 8'h00;
        run_txn(0, 24'h000000, "le_div1");
        check("le_div1_const", 64'(dat0), 64'h00100513);
        run_txn(1, 24'h000000, "be_div3");
        check("be_div3_const", 64'(dat1), 64'h13051000);

        // Address wrap inside the flash
        fmem[24'hFFFFFE] = 8'hAA; fmem[24'hFFFFFF] = 8'hBB;
        fmem[0] = 8'h11; fmem[1] = 8'h22;
        run_txn(0, 24'hFFFFFE, "wrap");
        check("wrap_const", 64'(dat0), 64'h2211BBAA);

        // Random addresses and contents, unaligned, with idle gaps
        for (int i = 0; i < 8; i++) begin
            a = 24'($urandom);
            for (int j = 0; j < 4; j++) fmem[int'(24'(a + 24'(j)))] = 8'($urandom);
            repeat ($urandom_range(0, 4)) @(negedge clock);
            run_txn((i % 3 == 2) ? 1 : 0, a, (i % 3 == 2) ? "rnd_be" : "rnd_le");
        end

        // req_valid held high, address changing every cycle
        wait_ready(0, "b2b");
        rv0 = 1'b1;
        cyc = 0; nacc = 0; nrsp = 0; last_acc = 0; gap = 0;
        while (nrsp < 3 && cyc < 600) begin
            if (vld0 === 1'b1) begin
                a = aq.pop_front();
                check("b2b_mosi", 64'(fcap[0]), 64'({8'h03, a}));
                check("b2b_data", 64'(dat0), 64'(exp_word(a, 1'b1)));
                nrsp++;
            end
            if (nrsp == 3) rv0 = 1'b0;
            ra0 = 24'($urandom);
            if (cs0 === 1'b0) gap = 0; else gap++;
            if (rdy0 === 1'b1 && rv0 === 1'b1) begin
                if (nacc > 0) begin
                    check("b2b_period", 64'(cyc - last_acc), 64'd130);
                    check("b2b_cs_gap", 64'(gap >= 1), 64'd1);
                end
                aq.push_back(ra0);
                last_acc = cyc;
                nacc++;
            end
            @(negedge clock);
            cyc++;
        end
        check("b2b_responses", 64'(nrsp), 64'd3);
        check("b2b_accepts", 64'(nacc), 64'd3);

        // Reset during bit 40 of the transfer
        wait_ready(0, "abort");
        set_req(0, 1'b1, 24'h123456);
        @(negedge clock);
        set_req(0, 1'b0, 24'h0);
        repeat (80) @(negedge clock);
        check("abort_mid_cs", 64'(cs0), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        check("abort_pins", 64'({cs0, sck0, vld0, rdy0}), 64'b1000);
        check("abort_data", 64'(dat0), 64'd0);
        reset = 1'b0;
        wait_powerup("abort");
        k = 0;
        repeat (150) begin @(negedge clock); if (vld0 === 1'b1) k++; end
        check("abort_no_rsp", 64'(k), 64'd0);

        // Recovery after the abort
        a = 24'($urandom);
        run_txn(0, a, "recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
